// File: rtl/apb_mux_pkg.sv
// Shared types and helpers for the multi-slave APB master.
package apb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Width of the slave index field; a single slave still gets one bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path selection (prdata/pready/pslverr) and one-hot psel for the addressed slave.
module apb_slave_mux #(
    parameter int NSLV   = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]       i_idx,
    input  logic                   i_active,
    input  logic [NSLV*DATA_W-1:0] i_prdata,
    input  logic [NSLV-1:0]        i_pready,
    input  logic [NSLV-1:0]        i_pslverr,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_ready,
    output logic                   o_slverr,
    output logic [NSLV-1:0]        o_psel
);

    logic [DATA_W-1:0] w_slice [NSLV];

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
            assign w_slice[gi] = i_prdata[gi*DATA_W +: DATA_W];
            assign o_psel[gi]  = i_active && (i_idx == SEL_W'(gi));
        end
    endgenerate

    // NSLV is a power of two, so every index value names a real slave.
    assign o_rdata  = w_slice[i_idx];
    assign o_ready  = i_pready[i_idx];
    assign o_slverr = i_pslverr[i_idx];

endmodule

// File: rtl/apb_master_mux.sv
// APB master driving one of NSLV slaves decoded from the upper address bits,
// with wait states, PSLVERR capture, ACCESS timeout and back-to-back transfers.
module apb_master_mux
    import apb_mux_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   newd,
    output logic                   req_ready,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      addrin,
    input  logic [DATA_W-1:0]      datain,
    input  logic [DATA_W/8-1:0]    strbin,
    output logic [DATA_W-1:0]      dataout,
    output logic                   done,
    output logic                   err,
    output logic                   timeout_err,
    output logic [ADDR_W-1:0]      paddr,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [DATA_W-1:0]      pwdata,
    output logic [DATA_W/8-1:0]    pstrb,
    input  logic [NSLV*DATA_W-1:0] prdata,
    input  logic [NSLV-1:0]        pready,
    input  logic [NSLV-1:0]        pslverr
);

    localparam int SEL_W  = sel_width(NSLV);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_pwrite;
    logic [SEL_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_dataout;
    logic                r_done;
    logic                r_err;
    logic                r_tout;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:0]   w_sel_rdata;
    logic                w_sel_ready;
    logic                w_sel_err;
    logic [NSLV-1:0]     w_psel;
    logic                w_last;
    logic                w_complete;
    logic                w_accept;

    apb_slave_mux #(
        .NSLV   (NSLV),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_slave_mux (
        .i_idx     (r_idx),
        .i_active  (r_state != IDLE),
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr),
        .o_rdata   (w_sel_rdata),
        .o_ready   (w_sel_ready),
        .o_slverr  (w_sel_err),
        .o_psel    (w_psel)
    );

    // The watchdog edge completes the transfer even with pready still low.
    assign w_last     = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_complete = (r_state == ACCESS) && (w_sel_ready || w_last);
    assign req_ready  = !preset && ((r_state == IDLE) || w_complete);
    assign w_accept   = newd && req_ready;

    assign psel        = w_psel;
    assign penable     = (r_state == ACCESS);
    assign paddr       = r_paddr;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign dataout     = r_dataout;
    assign done        = r_done;
    assign err         = r_err;
    assign timeout_err = r_tout;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pwrite  <= 1'b0;
            r_idx     <= '0;
            r_dataout <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tout    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_tout <= 1'b0;

            // Acceptance only happens in IDLE or on a completing ACCESS edge.
            if (w_accept) begin
                r_paddr  <= addrin;
                r_pwdata <= datain;
                r_pstrb  <= wr ? strbin : '0;
                r_pwrite <= wr;
                r_idx    <= addrin[ADDR_W-1 -: SEL_W];
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= SETUP;
                end
                SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (w_complete) begin
                        r_done <= 1'b1;
                        r_err  <= w_sel_ready ? w_sel_err : 1'b1;
                        r_tout <= !w_sel_ready;
                        if (w_sel_ready && !w_sel_err && !r_pwrite)
                            r_dataout <= w_sel_rdata;
                        r_state <= w_accept ? SETUP : IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: write, wait-state read, PSLVERR, timeout,
// back-to-back and mid-transfer reset.
module tb_apb_master_mux;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int NSLV    = 4;
    localparam int TIMEOUT = 16;

    logic                   pclk = 1'b0;
    logic                   preset = 1'b1;
    logic                   newd = 1'b0;
    logic                   req_ready;
    logic                   wr = 1'b0;
    logic [ADDR_W-1:0]      addrin = '0;
    logic [DATA_W-1:0]      datain = '0;
    logic [DATA_W/8-1:0]    strbin = '0;
    logic [DATA_W-1:0]      dataout;
    logic                   done;
    logic                   err;
    logic                   timeout_err;
    logic [ADDR_W-1:0]      paddr;
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [DATA_W-1:0]      pwdata;
    logic [DATA_W/8-1:0]    pstrb;
    logic [NSLV*DATA_W-1:0] prdata = '0;
    logic [NSLV-1:0]        pready = '0;
    logic [NSLV-1:0]        pslverr = '0;

    int n_total = 0;
    int n_pass  = 0;

    apb_master_mux #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .newd        (newd),
        .req_ready   (req_ready),
        .wr          (wr),
        .addrin      (addrin),
        .datain      (datain),
        .strbin      (strbin),
        .dataout     (dataout),
        .done        (done),
        .err         (err),
        .timeout_err (timeout_err),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic smp();
        @(negedge pclk);
    endtask

    // Present a request from IDLE; it is accepted on the next edge.
    task automatic req(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
        wr = w; addrin = a; datain = d; strbin = s; newd = 1'b1;
        $display("txn %s addr=%02h data=%08h strb=%0h", w ? "WR" : "RD", a, d, s);
        tick();
        newd = 1'b0;
    endtask

    initial begin
        int n_acc;
        logic got_done;

        // Reset state
        smp();
        check("rst_psel", 64'(psel), 64'h0);
        check("rst_penable", 64'(penable), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_dataout", 64'(dataout), 64'h0);
        check("rst_paddr", 64'(paddr), 64'h0);
        tick(); tick();
        preset = 1'b0;
        smp();
        check("post_rst_req_ready", 64'(req_ready), 64'h1);

        // Write, zero wait states, slave 1
        pready = 4'b0010;
        req(1'b1, 8'h44, 32'hDEADBEEF, 4'hF);
        smp();
        check("wr_setup_psel", 64'(psel), 64'h2);
        check("wr_setup_penable", 64'(penable), 64'h0);
        check("wr_setup_paddr", 64'(paddr), 64'h44);
        check("wr_setup_pwdata", 64'(pwdata), 64'hDEADBEEF);
        check("wr_setup_pstrb", 64'(pstrb), 64'hF);
        check("wr_setup_pwrite", 64'(pwrite), 64'h1);
        tick(); smp();
        check("wr_acc_penable", 64'(penable), 64'h1);
        check("wr_acc_req_ready", 64'(req_ready), 64'h1);
        check("wr_acc_done", 64'(done), 64'h0);
        tick(); smp();
        check("wr_done", 64'(done), 64'h1);
        check("wr_err", 64'(err), 64'h0);
        check("wr_psel_idle", 64'(psel), 64'h0);
        check("wr_paddr_held", 64'(paddr), 64'h44);
        tick(); smp();
        check("wr_done_pulse", 64'(done), 64'h0);

        // Read, 3 wait states, slave 3
        pready = '0;
        prdata[3*DATA_W +: DATA_W] = 32'h0000_00A5;
        req(1'b0, 8'hC8, 32'h0, 4'hF);
        smp();
        check("rd_setup_psel", 64'(psel), 64'h8);
        check("rd_setup_pstrb", 64'(pstrb), 64'h0);
        check("rd_setup_pwrite", 64'(pwrite), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); smp();
            check($sformatf("rd_acc%0d_penable", i), 64'(penable), 64'h1);
            check($sformatf("rd_acc%0d_done", i), 64'(done), 64'h0);
            if (i == 3) pready[3] = 1'b1;
        end
        tick();
        pready = '0;
        smp();
        check("rd_done", 64'(done), 64'h1);
        check("rd_err", 64'(err), 64'h0);
        check("rd_tout", 64'(timeout_err), 64'h0);
        check("rd_dataout", 64'(dataout), 64'hA5);

        // PSLVERR read on slave 0
        prdata[0 +: DATA_W] = 32'h12345678;
        pready = 4'b0001;
        pslverr = 4'b0001;
        req(1'b0, 8'h10, 32'h0, 4'h0);
        smp();
        check("se_setup_psel", 64'(psel), 64'h1);
        tick(); smp();
        tick(); smp();
        check("se_done", 64'(done), 64'h1);
        check("se_err", 64'(err), 64'h1);
        check("se_tout", 64'(timeout_err), 64'h0);
        check("se_dataout_held", 64'(dataout), 64'hA5);
        pready = '0;
        pslverr = '0;

        // Timeout on slave 2; other slaves' pready must be ignored
        pready = 4'b1011;
        req(1'b0, 8'h80, 32'h0, 4'h0);
        n_acc = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (penable) n_acc++;
            tick();
        end
        check("to_seen_done", 64'(got_done), 64'h1);
        check("to_access_cycles", 64'(n_acc), 64'(TIMEOUT));
        check("to_err", 64'(err), 64'h1);
        check("to_tout", 64'(timeout_err), 64'h1);
        check("to_psel", 64'(psel), 64'h0);
        check("to_dataout_held", 64'(dataout), 64'hA5);

        // Back-to-back: write slave 0 then read slave 2
        pready = 4'b0101;
        prdata[2*DATA_W +: DATA_W] = 32'hCAFEF00D;
        $display("txn WR addr=04 data=11111111 strb=3 then RD addr=84 back-to-back");
        wr = 1'b1; addrin = 8'h04; datain = 32'h11111111; strbin = 4'h3; newd = 1'b1;
        tick();
        wr = 1'b0; addrin = 8'h84;
        smp();
        check("b2b_s1_psel", 64'(psel), 64'h1);
        check("b2b_s1_penable", 64'(penable), 64'h0);
        check("b2b_s1_req_ready", 64'(req_ready), 64'h0);
        tick(); smp();
        check("b2b_a1_penable", 64'(penable), 64'h1);
        check("b2b_a1_req_ready", 64'(req_ready), 64'h1);
        tick();
        newd = 1'b0;
        smp();
        check("b2b_done1", 64'(done), 64'h1);
        check("b2b_s2_psel", 64'(psel), 64'h4);
        check("b2b_s2_penable", 64'(penable), 64'h0);
        check("b2b_s2_paddr", 64'(paddr), 64'h84);
        check("b2b_s2_pstrb", 64'(pstrb), 64'h0);
        tick(); smp();
        check("b2b_gap_done", 64'(done), 64'h0);
        check("b2b_a2_psel", 64'(psel), 64'h4);
        check("b2b_a2_penable", 64'(penable), 64'h1);
        tick(); smp();
        check("b2b_done2", 64'(done), 64'h1);
        check("b2b_err2", 64'(err), 64'h0);
        check("b2b_dataout", 64'(dataout), 64'hCAFEF00D);
        check("b2b_idle_psel", 64'(psel), 64'h0);
        pready = '0;

        // Reset held 5 cycles in the middle of an ACCESS phase
        req(1'b0, 8'h80, 32'h0, 4'h0);
        smp();
        tick(); smp();
        check("mr_in_access", 64'(penable), 64'h1);
        preset = 1'b1;
        #1;
        check("mr_psel_now", 64'(psel), 64'h0);
        check("mr_penable_now", 64'(penable), 64'h0);
        for (int i = 0; i < 5; i++) begin
            tick(); smp();
            check($sformatf("mr%0d_psel", i), 64'(psel), 64'h0);
            check($sformatf("mr%0d_done", i), 64'(done), 64'h0);
            check($sformatf("mr%0d_dataout", i), 64'(dataout), 64'h0);
        end
        tick();
        preset = 1'b0;
        smp();
        check("mr_req_ready", 64'(req_ready), 64'h1);
        check("mr_done_after", 64'(done), 64'h0);
        tick(); smp();
        check("mr_done_after2", 64'(done), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised next-generation APB master.
- Takes single-beat read/write requests from a local command interface and runs APB SETUP/ACCESS phases to one of NSLV slaves, selected by decoding the upper address bits.
- Adds over the single-slave master: configurable widths, wait-state handling, PSLVERR capture, a timeout watchdog and back-to-back transfers.
- Sits between the system controller and the APB peripheral fabric.

Parameters:
ADDR_W, 8, address width; the slave index is addr[ADDR_W-1 -: SEL_W]
DATA_W, 32, data width; multiple of 8
NSLV, 4, number of slaves; power of two, at least 2; SEL_W = clog2(NSLV)
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before the transfer is aborted; at least 2

Ports:
pclk  in  1  clock
preset  in  1  reset, asynchronous, active-high
newd  in  1  request valid
req_ready  out  1  request accepted this cycle when newd & req_ready
wr  in  1  1 = write, 0 = read
addrin  in  ADDR_W  request address
datain  in  DATA_W  write data
strbin  in  DATA_W/8  write byte strobes
dataout  out  DATA_W  read data of last successful read
done  out  1  one-cycle completion pulse
err  out  1  valid with done: PSLVERR or timeout
timeout_err  out  1  valid with done: timeout cause
paddr  out  ADDR_W  APB address
psel  out  NSLV  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes (forced 0 on reads)
prdata  in  NSLV*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
pready  in  NSLV  per-slave ready
pslverr  in  NSLV  per-slave error

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high.
- Reset: while preset=1, every output is 0 and the FSM is in IDLE. Reset mid-transfer drops psel/penable immediately; no done is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- req_ready = (state==IDLE) | (state==ACCESS & completing). It is combinational on the selected pready and the timeout counter.
- IDLE: on newd & req_ready, register addr/data/strb/wr and the decoded index; go to SETUP.
- SETUP (exactly 1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb valid; go to ACCESS.
- ACCESS: psel[idx]=1, penable=1. All APB outputs stay stable until completion.
- Normal completion: on an edge where pready[idx]=1.
  - Next cycle: done=1, err=pslverr[idx] sampled on that same edge, timeout_err=0.
  - Successful read (err=0): dataout loads the prdata slice on the completion edge.
  - Error read: dataout holds its previous value.
- Timeout: a counter clears on entering ACCESS and increments each ACCESS cycle with pready[idx]=0. When it reaches TIMEOUT-1 and pready is still 0, that edge terminates the transfer with done=1, err=1, timeout_err=1.
- After completion:
  - If newd was accepted in the completing cycle (back-to-back), go directly to SETUP. psel/penable drop for no cycle other than penable=0 in that SETUP.
  - Otherwise go to IDLE with psel=0, penable=0.
- Held outputs: paddr/pwdata keep their last values in IDLE. done/err/timeout_err are pulses, 0 otherwise.
- Latency: an accepted request at edge T gives SETUP in cycle T..T+1 and ACCESS from T+1. With zero wait states, completion is at edge T+2 and done is high during cycle T+2..T+3.
- Decode: idx = addrin[ADDR_W-1 -: SEL_W], full paddr forwarded unchanged. Exactly one psel bit is high outside IDLE.
- pready/pslverr from non-selected slaves are ignored.
- newd with req_ready=0 is not accepted; the requester must hold it.

Decomposition:
- Package apb_mux_pkg: state enum typedef (IDLE/SETUP/ACCESS) and a clog2-based SEL_W helper function.
- One natural sub-module, apb_slave_mux: combinational selection of prdata/pready/pslverr by idx and one-hot psel generation.
- FSM, timeout counter and registers stay in the top.

Test Plan:
- Reset: preset held 1 for 5 cycles mid-transfer -> psel=0, penable=0, dataout=0, no done pulse; after release, req_ready=1.
- Write, zero wait: addrin=8'h44, datain=32'hDEADBEEF, strbin=4'hF, pready[1]=1 -> psel=4'b0010; SETUP 1 cycle, ACCESS 1 cycle; done at cycle 3, err=0.
- Read, 3 wait states: addrin=8'hC8, slave 3 drives prdata=32'h0000_00A5 with pready after 3 cycles -> penable high 4 cycles, dataout=32'hA5, done=1, err=0; read pstrb=0.
- PSLVERR: read on slave 0 with pready=1, pslverr=1 -> done=1, err=1, timeout_err=0, dataout unchanged.
- Timeout: pready[2] held 0 -> abort after exactly TIMEOUT=16 ACCESS cycles; done=1, err=1, timeout_err=1; psel=0 next cycle.
- Back-to-back: newd held with write to 8'h04 then read to 8'h84 -> second SETUP immediately follows first completion (psel switches 0001 to 0100, penable=0 for one cycle); two done pulses 2 cycles apart.
